scic_io_port: RTL and testbench

- Parametrised memory-mapped I/O peripheral for the SCIC processor. It replaces the fixed 4-switch / 4-LED wiring.
- Synchronises and debounces SW_WIDTH switch inputs and latches per-bit change flags.
- Drives a LED_WIDTH output register and raises an interrupt on enabled switch changes.
- Sits between the SCIC core's I/O bus and the board pins.

---
 rtl/scic_io_port.sv | 150 +++++++++++++++
 tb/tb_scic_io_port.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/scic_io_port.sv
// scic_io_port: memory-mapped switch/LED peripheral for the SCIC core.
//
// The switch inputs pass through a two-flop synchroniser and a per-bit
// debouncer. Each accepted level change latches a CHANGE flag. An enabled
// CHANGE flag raises a level interrupt. The LED register drives the pins.
//
// Ports:
//   clock     - system clock; all state updates on its rising edge
//   reset     - synchronous, active-high reset
//   switches  - raw asynchronous switch levels
//   leds      - registered LED drive (mirror of the LED register)
//   addr      - 0=SW_STATE (RO), 1=LED (RW), 2=CHANGE (W1C), 3=IRQ_EN (RW)
//   wr_en     - one-cycle write strobe
//   rd_en     - one-cycle read strobe
//   wr_data   - write data; bits above the target register width are ignored
//   rd_data   - registered read data; holds its value between reads
//   rd_valid  - high for the cycle after each accepted read
//   irq       - registered level interrupt, |(CHANGE & IRQ_EN)
module scic_io_port #(
  parameter int SW_WIDTH        = 4,
  parameter int LED_WIDTH       = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DATA_WIDTH      = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [SW_WIDTH-1:0]   switches,
  output logic [LED_WIDTH-1:0]  leds,
  input  logic [1:0]            addr,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  irq
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SW_WIDTH-1:0]          s1_r;
  logic [SW_WIDTH-1:0]          s2_r;
  logic [SW_WIDTH-1:0]          stable_r;
  logic [SW_WIDTH-1:0][CW-1:0]  cnt_r;
  logic [SW_WIDTH-1:0]          change_r;
  logic [SW_WIDTH-1:0]          irq_en_r;
  logic [LED_WIDTH-1:0]         led_r;
  logic [DATA_WIDTH-1:0]        rd_data_r;
  logic                         rd_valid_r;
  logic                         irq_r;

  logic [SW_WIDTH-1:0]          stable_next_s;
  logic [SW_WIDTH-1:0][CW-1:0]  cnt_next_s;
  logic [SW_WIDTH-1:0]          set_s;
  logic [SW_WIDTH-1:0]          w1c_s;
  logic [SW_WIDTH-1:0]          change_next_s;
  logic [SW_WIDTH-1:0]          irq_en_next_s;
  logic [LED_WIDTH-1:0]         led_next_s;
  logic [DATA_WIDTH-1:0]        rd_mux_s;

  // Only the low register-width bits of wr_data are meaningful.
  logic unused_wr_bits_s;
  assign unused_wr_bits_s = ^wr_data;

  assign leds     = led_r;
  assign rd_data  = rd_data_r;
  assign rd_valid = rd_valid_r;
  assign irq      = irq_r;

  // Per-bit debouncer: count consecutive cycles where the synchronised level
  // differs from the accepted level; accept it on the DEBOUNCE_CYCLES-th one.
  always_comb begin
    stable_next_s = stable_r;
    cnt_next_s    = cnt_r;
    set_s         = '0;
    for (int i = 0; i < SW_WIDTH; i++) begin
      if (s2_r[i] == stable_r[i]) begin
        cnt_next_s[i] = '0;
      end else if (cnt_r[i] == CNT_LAST) begin
        stable_next_s[i] = s2_r[i];
        cnt_next_s[i]    = '0;
        set_s[i]         = 1'b1;
      end else begin
        cnt_next_s[i] = cnt_r[i] + CW'(1);
      end
    end
  end

  // Write decode and next register values; a debounce set beats a W1C clear.
  always_comb begin
    w1c_s         = '0;
    irq_en_next_s = irq_en_r;
    led_next_s    = led_r;
    if (wr_en) begin
      case (addr)
        2'd1:    led_next_s    = wr_data[LED_WIDTH-1:0];
        2'd2:    w1c_s         = wr_data[SW_WIDTH-1:0];
        2'd3:    irq_en_next_s = wr_data[SW_WIDTH-1:0];
        default: w1c_s         = '0;  // SW_STATE is read-only
      endcase
    end else begin
      w1c_s = '0;
    end
    change_next_s = (change_r & ~w1c_s) | set_s;
  end

  // Read multiplexer over current (pre-write) register contents, zero-extended.
  always_comb begin
    rd_mux_s = '0;
    case (addr)
      2'd0:    rd_mux_s[SW_WIDTH-1:0]  = stable_r;
      2'd1:    rd_mux_s[LED_WIDTH-1:0] = led_r;
      2'd2:    rd_mux_s[SW_WIDTH-1:0]  = change_r;
      2'd3:    rd_mux_s[SW_WIDTH-1:0]  = irq_en_r;
      default: rd_mux_s = '0;
    endcase
  end

  // All state registers, synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_r       <= '0;
      s2_r       <= '0;
      stable_r   <= '0;
      cnt_r      <= '0;
      change_r   <= '0;
      irq_en_r   <= '0;
      led_r      <= '0;
      rd_data_r  <= '0;
      rd_valid_r <= 1'b0;
      irq_r      <= 1'b0;
    end else begin
      s1_r       <= switches;
      s2_r       <= s1_r;
      stable_r   <= stable_next_s;
      cnt_r      <= cnt_next_s;
      change_r   <= change_next_s;
      irq_en_r   <= irq_en_next_s;
      led_r      <= led_next_s;
      irq_r      <= |(change_next_s & irq_en_next_s);
      rd_valid_r <= rd_en;
      if (rd_en) begin
        rd_data_r <= rd_mux_s;
      end else begin
        rd_data_r <= rd_data_r;
      end
    end
  end

endmodule

// File: tb/tb_scic_io_port.sv
// Self-checking bench for scic_io_port: directed scenarios followed by a
// randomized run. A reference model predicts each read result into a queue;
// a monitor on the falling edge pops and compares whenever rd_valid is high,
// and also checks leds, irq and rd_data hold behaviour every cycle.
module tb_scic_io_port;

  localparam int DEB = 4;

  logic        clock;
  logic        reset;
  logic [3:0]  switches;
  logic [3:0]  leds;
  logic [1:0]  addr;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        irq;

  int checks = 0;
  int errors = 0;

  scic_io_port #(
    .SW_WIDTH(4), .LED_WIDTH(4), .DEBOUNCE_CYCLES(DEB), .DATA_WIDTH(32)
  ) dut (
    .clock(clock), .reset(reset), .switches(switches), .leds(leds),
    .addr(addr), .wr_en(wr_en), .rd_en(rd_en), .wr_data(wr_data),
    .rd_data(rd_data), .rd_valid(rd_valid), .irq(irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model state
  bit [3:0]  m_s1, m_s2, m_stable, m_change, m_irq_en, m_led;
  bit        m_irq;
  bit [3:0]  hist [DEB];   // last DEB synchronised samples seen by the debouncer
  bit [3:0]  all_diff, setm, w1c;
  bit [31:0] rv, last_rd, e;
  bit [31:0] exp_q [$];

  // Model: a bit's accepted level flips once its last DEB synchronised
  // samples all disagree with the currently accepted level.
  always @(posedge clock) begin
    if (reset) begin
      m_s1 = 4'd0; m_s2 = 4'd0; m_stable = 4'd0; m_change = 4'd0;
      m_irq_en = 4'd0; m_led = 4'd0; m_irq = 1'b0; last_rd = 32'd0;
      for (int i = 0; i < DEB; i++) hist[i] = 4'd0;
      exp_q.delete();
    end else begin
      if (rd_en) begin
        case (addr)
          2'd0:    rv = {28'd0, m_stable};
          2'd1:    rv = {28'd0, m_led};
          2'd2:    rv = {28'd0, m_change};
          default: rv = {28'd0, m_irq_en};
        endcase
        exp_q.push_back(rv);
      end
      for (int i = 0; i < DEB - 1; i++) hist[i] = hist[i+1];
      hist[DEB-1] = m_s2;
      all_diff = 4'hF;
      for (int i = 0; i < DEB; i++) all_diff &= hist[i] ^ m_stable;
      setm = all_diff;
      m_stable ^= setm;
      w1c = (wr_en && addr == 2'd2) ? wr_data[3:0] : 4'd0;
      m_change = (m_change & ~w1c) | setm;
      if (wr_en && addr == 2'd3) m_irq_en = wr_data[3:0];
      if (wr_en && addr == 2'd1) m_led = wr_data[3:0];
      m_irq = |(m_change & m_irq_en);
      m_s2 = m_s1;
      m_s1 = switches;
    end
  end

  // Monitor: compare outputs away from the active edge.
  always @(negedge clock) begin
    checks++;
    if (leds !== m_led) begin
      errors++;
      $display("FAIL leds @%0t: got %h expected %h", $time, leds, m_led);
    end
    checks++;
    if (irq !== m_irq) begin
      errors++;
      $display("FAIL irq @%0t: got %b expected %b", $time, irq, m_irq);
    end
    checks++;
    if (rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rd_valid @%0t: got rd_valid=1 expected 0", $time);
      end else begin
        e = exp_q.pop_front();
        last_rd = e;
        if (rd_data !== e) begin
          errors++;
          $display("FAIL rd_data @%0t: got %h expected %h", $time, rd_data, e);
        end
      end
    end else if (rd_valid === 1'b0) begin
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL missing_rd_valid @%0t: got rd_valid=0 expected 1", $time);
        exp_q.delete();
      end else if (rd_data !== last_rd) begin
        errors++;
        $display("FAIL rd_data_hold @%0t: got %h expected %h", $time, rd_data, last_rd);
      end
    end else begin
      errors++;
      $display("FAIL rd_valid_x @%0t: got %b expected 0 or 1", $time, rd_valid);
    end
  end

  task automatic step(input logic [3:0] sw, input logic [1:0] a,
                      input logic we, input logic re, input logic [31:0] wd);
    switches = sw; addr = a; wr_en = we; rd_en = re; wr_data = wd;
    @(negedge clock);
  endtask

  logic [3:0] sw_cur;
  int         hold;

  initial begin
    // 1: reset for 3 cycles (reads during reset are dropped), then read SW_STATE
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step(4'h0, 2'd0, 1'b0, 1'b1, 32'd0);
    reset = 1'b0;
    step(4'h0, 2'd0, 1'b0, 1'b1, 32'd0);
    // 2: LED write with junk upper bits, then read back
    step(4'h0, 2'd1, 1'b1, 1'b0, 32'hFFFF_FFFA);
    step(4'h0, 2'd1, 1'b0, 1'b1, 32'd0);
    // read and write same address in one cycle returns the pre-write value
    step(4'h0, 2'd1, 1'b1, 1'b1, 32'h0000_0003);
    // 3: hold 0101, back-to-back SW_STATE reads, then CHANGE
    for (int i = 0; i < 9; i++) step(4'h5, 2'd0, 1'b0, 1'b1, 32'd0);
    step(4'h5, 2'd2, 1'b0, 1'b1, 32'd0);
    // 3-cycle glitch on bit 3 must be rejected
    for (int i = 0; i < 3; i++) step(4'hD, 2'd0, 1'b0, 1'b1, 32'd0);
    for (int i = 0; i < 8; i++) step(4'h5, 2'(i % 2 * 2), 1'b0, 1'b1, 32'd0);
    // 4: clear CHANGE, enable bit 0 interrupt, drop bit 0, then W1C it
    step(4'h5, 2'd2, 1'b1, 1'b0, 32'hF);
    step(4'h5, 2'd3, 1'b1, 1'b0, 32'h1);
    for (int i = 0; i < 8; i++) step(4'h4, 2'd2, 1'b0, 1'b1, 32'd0);
    step(4'h4, 2'd2, 1'b1, 1'b0, 32'h1);
    step(4'h4, 2'd2, 1'b0, 1'b1, 32'd0);
    step(4'h4, 2'd0, 1'b0, 1'b0, 32'd0);
    // 5: bit 2 falls; W1C of bit 2 lands on the edge where debounce completes
    step(4'h0, 2'd0, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 4; i++) step(4'h0, 2'd0, 1'b0, 1'b0, 32'd0);
    step(4'h0, 2'd2, 1'b1, 1'b0, 32'h4);
    step(4'h0, 2'd2, 1'b0, 1'b1, 32'd0);
    // 6: reset two cycles into a debounce; debounce must restart from scratch
    step(4'h2, 2'd0, 1'b0, 1'b1, 32'd0);
    step(4'h2, 2'd0, 1'b0, 1'b1, 32'd0);
    reset = 1'b1;
    step(4'h2, 2'd0, 1'b0, 1'b0, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 9; i++) step(4'h2, 2'd0, 1'b0, 1'b1, 32'd0);
    // Randomized run: held levels, short glitches, random bus traffic
    sw_cur = 4'h2;
    hold = 0;
    for (int n = 0; n < 3000; n++) begin
      if (hold == 0) begin
        sw_cur ^= 4'($urandom_range(0, 15));
        hold = $urandom_range(1, 9);
      end
      hold--;
      reset = ($urandom_range(0, 399) == 0);
      step(sw_cur, 2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 2) != 0), $urandom());
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step(sw_cur, 2'd0, 1'b0, 1'b0, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
